line_scene_sequencer: RTL and testbench
=======================================

// Module: line_scene_sequencer
// PURPOSE
//  Sequences the line renderer: derives one-cycle next_row/next_frame strobes from the
//  VGA beam position and drives the renderer's mode (scene) and frame (time-in-scene).
//  Scenes advance automatically after a per-scene frame count, or on a user step request.
//  mode/frame change only on frame boundaries, so they are stable for the whole frame.
// PARAMETERS
//  H_LAST      799  last x_pos of a scanline (H total - 1); one pixel per clk
//  V_LAST      524  last y_pos of a frame (V total - 1)
//  NUM_SCENES  4    number of scenes; mode wraps NUM_SCENES-1 -> 0
// PORTS
//  clk          in   1   pixel clock; single clock domain
//  rst          in   1   reset, asynchronous, active-high
//  x_pos        in   10  beam x from VGA timing
//  y_pos        in   10  beam y from VGA timing
//  pause        in   1   level: freeze frame count and auto-advance
//  step         in   1   pulse: request advance to next scene at next frame boundary
//  next_row     out  1   one-cycle strobe, start of each scanline (except frame start)
//  next_frame   out  1   one-cycle strobe, start of each frame
//  scene_start  out  1   one-cycle strobe, coincident with next_frame when mode changed
//  mode         out  4   current scene index to line renderer
//  frame        out  10  frames elapsed in current scene
// BEHAVIOUR
//  Reset (async): next_row=0, next_frame=0, scene_start=0, mode=0, frame=0, step_pend=0,
//   state=RUN. All outputs registered; no combinational input->output paths.
//  Boundary detect: row_end = (x_pos==H_LAST); frm_end = row_end && (y_pos==V_LAST).
//  Strobes (latency 1): edge after row_end samples high, next_row<=row_end&&!frm_end,
//   next_frame<=frm_end. Never both high. Each lasts exactly 1 cycle.
//  step_pend: set on step=1; cleared on the edge that raises next_frame. step=1 in the
//   same cycle as frm_end counts for that boundary (pend then cleared, not re-set).
//  scene_len(mode): 10-bit frame count from package table; 0 = infinite (no auto-advance).
//  FSM (state updated on frm_end edge or pause change):
//   RUN:    on frm_end: if step_pend|step -> ADVANCE action;
//           elif len!=0 && frame==len-1 -> ADVANCE action; else frame<=frame+1.
//           pause=1 -> PAUSED (takes effect immediately, before the frm_end check).
//   PAUSED: frame, mode held. On frm_end with step_pend|step -> ADVANCE action, stay PAUSED.
//           pause=0 -> RUN.
//   ADVANCE action (same edge as next_frame rise): mode<=(mode==NUM_SCENES-1)?0:mode+1;
//    frame<=0; scene_start<=1.
//  frame saturates at 1023 (infinite scenes never wrap to 0 silently).
//  mode/frame/scene_start update on the same edge that raises next_frame, so the renderer
//   sees new values while next_frame=1 and for the whole following frame.
//  Mid-operation rst: all state cleared immediately; first boundary after release
//   behaves as from power-up (no spurious strobe on release).
//  x_pos/y_pos out of range (>H_LAST/>V_LAST): no strobes; state held.
// STRUCTURE
//  Package line_render_pkg: H_LAST/V_LAST defaults, SCENE_LEN table function,
//   typedef enum logic {RUN, PAUSED} seq_state_t, typedefs mode_t (4b), frame_t (10b).
//  Sub-module line_timing_strobes: row_end/frm_end detect + registered strobes.
//  Top: step_pend flag, FSM, mode/frame counters.
// TESTING
//  Free run, table len {3,5,0,2}: 8 frames -> mode 0,0,0,1,1,1,1,1; frame 0,1,2,0,1,2,3,4.
//  Strobes: x=799,y=10 -> next_row=1 next cycle only; x=799,y=524 -> next_frame=1, next_row=0.
//  step pulse at x=100,y=200 in mode 2 (infinite) -> mode 3, frame 0, scene_start=1 at next
//   next_frame; step with frm_end same cycle -> advance on that boundary, pend clear after.
//  pause=1 for 4 frames at mode 1 frame 2 -> frame stays 2, mode 1; release -> 3 next frame.
//  Wrap: mode 3 at frame 1 (len 2) -> mode 0, frame 0 at next boundary.
//  rst asserted mid-frame with mode 2 frame 7 -> all outputs 0 async; no strobe on release
//   until next x=799.

Source files
------------

// File: rtl/line_render_pkg.sv
// Shared types, timing defaults and the per-scene length table for the line renderer.
package line_render_pkg;

  localparam logic [9:0] H_LAST_DEF     = 10'd799;
  localparam logic [9:0] V_LAST_DEF     = 10'd524;
  localparam int         NUM_SCENES_DEF = 4;

  typedef enum logic {RUN, PAUSED} seq_state_t;
  typedef logic [3:0] mode_t;
  typedef logic [9:0] frame_t;

  localparam frame_t FRAME_MAX = 10'd1023;

  // Frames each scene lasts before auto-advancing; 0 means the scene never ends on its own.
  function automatic frame_t scene_len(input mode_t m);
    case (m)
      4'd0:    scene_len = 10'd3;
      4'd1:    scene_len = 10'd5;
      4'd2:    scene_len = 10'd0;
      4'd3:    scene_len = 10'd2;
      default: scene_len = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/line_timing_strobes.sv
// Detects end-of-row / end-of-frame from the beam position and registers one-cycle strobes.
module line_timing_strobes
  import line_render_pkg::*;
#(
  parameter logic [9:0] H_LAST = H_LAST_DEF,
  parameter logic [9:0] V_LAST = V_LAST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic       frm_end,
  output logic       next_row,
  output logic       next_frame
);

  logic in_range;
  logic row_end;
  logic next_row_d, next_row_q;
  logic next_frame_d, next_frame_q;

  // Beam positions outside the visible+blanking raster never produce a boundary.
  always_comb begin
    in_range     = (x_pos <= H_LAST) && (y_pos <= V_LAST);
    row_end      = in_range && (x_pos == H_LAST);
    frm_end      = row_end && (y_pos == V_LAST);
    next_row_d   = row_end && !frm_end;
    next_frame_d = frm_end;
  end

  // Strobes are registered so they rise on the edge after the boundary pixel, for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_row_q   <= 1'b0;
      next_frame_q <= 1'b0;
    end else begin
      next_row_q   <= next_row_d;
      next_frame_q <= next_frame_d;
    end
  end

  assign next_row   = next_row_q;
  assign next_frame = next_frame_q;

endmodule

// File: rtl/line_scene_sequencer.sv
// Drives the renderer's scene (mode) and time-in-scene (frame), advancing on frame boundaries.
module line_scene_sequencer
  import line_render_pkg::*;
#(
  parameter logic [9:0] H_LAST     = H_LAST_DEF,
  parameter logic [9:0] V_LAST     = V_LAST_DEF,
  parameter int         NUM_SCENES = NUM_SCENES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       pause,
  input  logic       step,
  output logic       next_row,
  output logic       next_frame,
  output logic       scene_start,
  output logic [3:0] mode,
  output logic [9:0] frame
);

  localparam mode_t LAST_MODE = mode_t'(NUM_SCENES - 1);

  logic       frm_end;
  seq_state_t state_d, state_q;
  mode_t      mode_d, mode_q;
  frame_t     frame_d, frame_q;
  logic       scene_start_d, scene_start_q;
  logic       step_pend_d, step_pend_q;
  logic       hold;
  logic       adv;
  frame_t     cur_len;

  line_timing_strobes #(
    .H_LAST (H_LAST),
    .V_LAST (V_LAST)
  ) u_strobes (
    .clk        (clk),
    .rst        (rst),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frm_end    (frm_end),
    .next_row   (next_row),
    .next_frame (next_frame)
  );

  // Next-state logic: pause freezes counting at once; a pending or same-cycle step wins at the boundary.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    frame_d       = frame_q;
    scene_start_d = 1'b0;
    step_pend_d   = step_pend_q;
    hold          = 1'b0;
    adv           = 1'b0;
    cur_len       = scene_len(mode_q);

    case (state_q)
      RUN: begin
        if (pause) begin
          state_d = PAUSED;
          hold    = 1'b1;
        end
      end
      PAUSED: begin
        hold = 1'b1;
        if (!pause) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (frm_end) begin
      // The boundary consumes the request, including a step arriving on the boundary itself.
      step_pend_d = 1'b0;
      if (step_pend_q || step) begin
        adv = 1'b1;
      end else if (!hold) begin
        if ((cur_len != 10'd0) && (frame_q == cur_len - 10'd1)) begin
          adv = 1'b1;
        end else if (frame_q != FRAME_MAX) begin
          frame_d = frame_q + 10'd1;
        end
      end
    end else if (step) begin
      step_pend_d = 1'b1;
    end

    if (adv) begin
      mode_d        = (mode_q == LAST_MODE) ? 4'd0 : mode_q + 4'd1;
      frame_d       = 10'd0;
      scene_start_d = 1'b1;
    end
  end

  // Sequencer state; mode/frame change only on the edge that raises next_frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      mode_q        <= 4'd0;
      frame_q       <= 10'd0;
      scene_start_q <= 1'b0;
      step_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      frame_q       <= frame_d;
      scene_start_q <= scene_start_d;
      step_pend_q   <= step_pend_d;
    end
  end

  assign scene_start = scene_start_q;
  assign mode        = mode_q;
  assign frame       = frame_q;

endmodule

// File: tb/tb_line_scene_sequencer.sv
// Self-checking bench for line_scene_sequencer with a frame-level reference model.
module tb_line_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       pause;
  logic       step;
  logic       next_row;
  logic       next_frame;
  logic       scene_start;
  logic [3:0] mode;
  logic [9:0] frame;

  int errors = 0;
  int checks = 0;

  // Reference model state: scene progression as described by the scene rules.
  int LEN[4] = '{3, 5, 0, 2};
  int m_mode, m_frame;
  bit m_pend, m_paused;
  bit exp_nr, exp_nf, exp_ss;

  line_scene_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .pause       (pause),
    .step        (step),
    .next_row    (next_row),
    .next_frame  (next_frame),
    .scene_start (scene_start),
    .mode        (mode),
    .frame       (frame)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_mode = 0; m_frame = 0; m_pend = 0; m_paused = 0;
    exp_nr = 0; exp_nf = 0; exp_ss = 0;
  endtask

  // Apply one cycle of inputs, advance the model, and land 1ns after the active edge.
  task automatic tick(input int x, input int y, input int p, input int s);
    bit re, fe;
    re = (x == 799) && (y <= 524);
    fe = re && (y == 524);
    x_pos = 10'(x); y_pos = 10'(y); pause = p[0]; step = s[0];
    exp_nr = re && !fe;
    exp_nf = fe;
    exp_ss = 0;
    if (fe) begin
      if (m_pend || s != 0) begin
        m_mode = (m_mode + 1) % 4; m_frame = 0; exp_ss = 1;
      end else if (p == 0 && !m_paused) begin
        if (LEN[m_mode] != 0 && m_frame + 1 == LEN[m_mode]) begin
          m_mode = (m_mode + 1) % 4; m_frame = 0; exp_ss = 1;
        end else if (m_frame < 1023) begin
          m_frame = m_frame + 1;
        end
      end
      m_pend = 0;
    end else if (s != 0) begin
      m_pend = 1;
    end
    m_paused = (p != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic filler(input int n, input int p);
    for (int i = 0; i < n; i++) tick($urandom_range(0, 798), $urandom_range(0, 524), p, 0);
  endtask

  task automatic boundary(input int p, input int s);
    tick(799, 524, p, s);
  endtask

  task automatic do_reset();
    x_pos = 10'd0; y_pos = 10'd0; pause = 1'b0; step = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    checks++; if (next_row !== 1'b0)    begin errors++; $display("FAIL reset_next_row: got %b want 0", next_row); end
    checks++; if (next_frame !== 1'b0)  begin errors++; $display("FAIL reset_next_frame: got %b want 0", next_frame); end
    checks++; if (scene_start !== 1'b0) begin errors++; $display("FAIL reset_scene_start: got %b want 0", scene_start); end
    checks++; if (mode !== 4'd0)        begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
    checks++; if (frame !== 10'd0)      begin errors++; $display("FAIL reset_frame: got %0d want 0", frame); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    int em[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int ef[8] = '{0, 1, 2, 0, 1, 2, 3, 4};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      checks++; if (mode !== 4'(em[k]))   begin errors++; $display("FAIL free_run_mode[%0d]: got %0d want %0d", k, mode, em[k]); end
      checks++; if (frame !== 10'(ef[k])) begin errors++; $display("FAIL free_run_frame[%0d]: got %0d want %0d", k, frame, ef[k]); end
      if (k < 7) begin
        filler(3, 0);
        boundary(0, 0);
        checks++; if (next_frame !== 1'b1) begin errors++; $display("FAIL free_run_next_frame[%0d]: got %b want 1", k, next_frame); end
        checks++; if (scene_start !== (k + 1 == 3)) begin errors++; $display("FAIL free_run_scene_start[%0d]: got %b want %b", k, scene_start, (k + 1 == 3)); end
      end
    end
  endtask

  task automatic test_strobes();
    logic [3:0] m0;
    logic [9:0] f0;
    do_reset();
    tick(799, 10, 0, 0);
    checks++; if (next_row !== 1'b1)   begin errors++; $display("FAIL strobe_row_rise: got %b want 1", next_row); end
    checks++; if (next_frame !== 1'b0) begin errors++; $display("FAIL strobe_row_nf: got %b want 0", next_frame); end
    tick(100, 10, 0, 0);
    checks++; if (next_row !== 1'b0)   begin errors++; $display("FAIL strobe_row_fall: got %b want 0", next_row); end
    tick(799, 524, 0, 0);
    checks++; if (next_frame !== 1'b1) begin errors++; $display("FAIL strobe_frame_rise: got %b want 1", next_frame); end
    checks++; if (next_row !== 1'b0)   begin errors++; $display("FAIL strobe_frame_nr: got %b want 0", next_row); end
    tick(0, 0, 0, 0);
    checks++; if (next_frame !== 1'b0) begin errors++; $display("FAIL strobe_frame_fall: got %b want 0", next_frame); end
    m0 = mode; f0 = frame;
    tick(900, 524, 0, 0);
    tick(799, 600, 0, 0);
    checks++; if ({next_row, next_frame} !== 2'b00) begin errors++; $display("FAIL strobe_out_of_range: got %b want 00", {next_row, next_frame}); end
    checks++; if (frame !== f0 || mode !== m0 || frame !== 10'(m_frame)) begin errors++; $display("FAIL strobe_oor_hold: got m%0d f%0d want m%0d f%0d", mode, frame, m_mode, m_frame); end
  endtask

  task automatic test_step();
    do_reset();
    boundary(0, 1);
    boundary(0, 1);
    for (int i = 0; i < 3; i++) begin filler(2, 0); boundary(0, 0); end
    checks++; if (mode !== 4'd2 || frame !== 10'd3) begin errors++; $display("FAIL step_setup: got m%0d f%0d want m2 f3", mode, frame); end
    tick(100, 200, 0, 1);
    filler(4, 0);
    boundary(0, 0);
    checks++; if (mode !== 4'd3 || frame !== 10'd0) begin errors++; $display("FAIL step_advance: got m%0d f%0d want m3 f0", mode, frame); end
    checks++; if (scene_start !== 1'b1) begin errors++; $display("FAIL step_scene_start: got %b want 1", scene_start); end
    tick(10, 10, 0, 0);
    checks++; if (scene_start !== 1'b0) begin errors++; $display("FAIL step_scene_start_fall: got %b want 0", scene_start); end
    filler(3, 0);
    boundary(0, 1);
    checks++; if (mode !== 4'd0 || frame !== 10'd0 || scene_start !== 1'b1) begin errors++; $display("FAIL step_on_boundary: got m%0d f%0d ss%b want m0 f0 ss1", mode, frame, scene_start); end
    filler(3, 0);
    boundary(0, 0);
    checks++; if (mode !== 4'd0 || frame !== 10'd1 || scene_start !== 1'b0) begin errors++; $display("FAIL step_pend_cleared: got m%0d f%0d ss%b want m0 f1 ss0", mode, frame, scene_start); end
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 5; i++) begin filler(2, 0); boundary(0, 0); end
    checks++; if (mode !== 4'd1 || frame !== 10'd2) begin errors++; $display("FAIL pause_setup: got m%0d f%0d want m1 f2", mode, frame); end
    for (int i = 0; i < 4; i++) begin
      filler(2, 1);
      boundary(1, 0);
      checks++; if (mode !== 4'd1 || frame !== 10'd2) begin errors++; $display("FAIL pause_hold[%0d]: got m%0d f%0d want m1 f2", i, mode, frame); end
    end
    tick(5, 5, 0, 0);
    filler(2, 0);
    boundary(0, 0);
    checks++; if (mode !== 4'd1 || frame !== 10'd3) begin errors++; $display("FAIL pause_release: got m%0d f%0d want m1 f3", mode, frame); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin filler(1, 0); boundary(0, 1); end
    filler(2, 0);
    boundary(0, 0);
    checks++; if (mode !== 4'd3 || frame !== 10'd1) begin errors++; $display("FAIL wrap_setup: got m%0d f%0d want m3 f1", mode, frame); end
    filler(2, 0);
    boundary(0, 0);
    checks++; if (mode !== 4'd0 || frame !== 10'd0 || scene_start !== 1'b1) begin errors++; $display("FAIL wrap: got m%0d f%0d ss%b want m0 f0 ss1", mode, frame, scene_start); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    boundary(0, 1);
    boundary(0, 1);
    for (int i = 0; i < 7; i++) begin filler(1, 0); boundary(0, 0); end
    checks++; if (mode !== 4'd2 || frame !== 10'd7) begin errors++; $display("FAIL rst_mid_setup: got m%0d f%0d want m2 f7", mode, frame); end
    tick(799, 10, 0, 0);
    #2;
    rst = 1'b1;
    x_pos = 10'd100;
    #1;
    checks++; if ({next_row, next_frame, scene_start} !== 3'b000 || mode !== 4'd0 || frame !== 10'd0) begin
      errors++; $display("FAIL rst_mid_async: got nr%b nf%b ss%b m%0d f%0d want all 0", next_row, next_frame, scene_start, mode, frame);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      tick(100 + i, 100, 0, 0);
      checks++; if ({next_row, next_frame, scene_start} !== 3'b000) begin errors++; $display("FAIL rst_release_quiet[%0d]: got %b want 000", i, {next_row, next_frame, scene_start}); end
    end
    tick(799, 10, 0, 0);
    checks++; if (next_row !== 1'b1 || mode !== 4'd0 || frame !== 10'd0) begin errors++; $display("FAIL rst_release_row: got nr%b m%0d f%0d want nr1 m0 f0", next_row, mode, frame); end
  endtask

  task automatic test_random();
    int r, x, y, p, s;
    do_reset();
    p = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin x = 799; y = 524; end
      else if (r < 5) begin x = 799; y = $urandom_range(0, 523); end
      else if (r == 5) begin
        if ($urandom_range(0, 1) == 0) begin x = $urandom_range(800, 1023); y = $urandom_range(0, 1023); end
        else begin x = 799; y = $urandom_range(525, 1023); end
      end
      else begin x = $urandom_range(0, 798); y = $urandom_range(0, 1023); end
      if ($urandom_range(0, 29) == 0) p = 1 - p;
      s = ($urandom_range(0, 11) == 0) ? 1 : 0;
      tick(x, y, p, s);
      checks++; if (next_row !== exp_nr)      begin errors++; $display("FAIL rand_next_row[%0d]: got %b want %b", i, next_row, exp_nr); end
      checks++; if (next_frame !== exp_nf)    begin errors++; $display("FAIL rand_next_frame[%0d]: got %b want %b", i, next_frame, exp_nf); end
      checks++; if (scene_start !== exp_ss)   begin errors++; $display("FAIL rand_scene_start[%0d]: got %b want %b", i, scene_start, exp_ss); end
      checks++; if (mode !== 4'(m_mode))      begin errors++; $display("FAIL rand_mode[%0d]: got %0d want %0d", i, mode, m_mode); end
      checks++; if (frame !== 10'(m_frame))   begin errors++; $display("FAIL rand_frame[%0d]: got %0d want %0d", i, frame, m_frame); end
    end
  endtask

  initial begin
    rst = 1'b1; x_pos = 10'd0; y_pos = 10'd0; pause = 1'b0; step = 1'b0;
    test_reset();
    test_free_run();
    test_strobes();
    test_step();
    test_pause();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
